zapper_ctrl: RTL

ZAPPER_CTRL -- requirements
Module: zapper_ctrl

---
 rtl/zapper_pkg.sv | 6 +
 rtl/sync_debounce.sv | 34 +++
 rtl/zapper_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/zapper_pkg.sv
// zapper_pkg: state type and default tuning constants shared by the light-gun controller
package zapper_pkg;
    localparam int DEBOUNCE_DEFAULT = 250000;
    localparam int HIT_DEFAULT      = 64;
    typedef enum logic [2:0] {IDLE, ARM, BLACK, TARGET, RESULT, HOLDOFF} state_t;
endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: 2-flop synchronizer followed by a stable-time debouncer
// clk/reset: clock, async active-low reset; din: raw async input; dout: debounced level
module sync_debounce
    import zapper_pkg::*;
#(
    parameter int CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W  = 18
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);
    logic s1, s2;
    logic [CNT_W-1:0] cnt;
    // cnt counts consecutive cycles where the synchronized input disagrees with dout
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == dout)
                cnt <= '0;
            else if (cnt == CNT_W'(CYCLES - 1)) begin
                cnt  <= '0;
                dout <= s2;
            end else
                cnt <= cnt + 1'b1;
        end
endmodule

// File: rtl/zapper_ctrl.sv
// zapper_ctrl: light-gun shot sequencer (black frame, target frame, hit/miss scoring)
// clk/reset: pixel clock, async active-low reset; trigger/detect: raw async gun inputs
// vsync (active-low)/valid: VGA timing; flash_black/flash_target: frame overrides
// hit/miss: one-cycle result pulses; busy: shot in progress
module zapper_ctrl
    import zapper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int HIT_THRESHOLD   = HIT_DEFAULT,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic reset,
    input  logic trigger,
    input  logic detect,
    input  logic vsync,
    input  logic valid,
    output logic flash_black,
    output logic flash_target,
    output logic hit,
    output logic miss,
    output logic busy
);
    state_t state;
    logic trig_db, trig_q, det_s1, det_s2, vs_q, cheat;
    logic shot, frame_start, lit_px, hit_ok;
    logic [CNT_W-1:0] light, light_nxt;

    sync_debounce #(.CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_trig (
        .clk(clk), .reset(reset), .din(trigger), .dout(trig_db)
    );

    assign shot        = trig_db & ~trig_q;
    assign frame_start = vs_q & ~vsync;
    assign lit_px      = valid & det_s2;
    // saturating increment; the score uses the post-increment value so the last pixel counts
    assign light_nxt   = light + CNT_W'(lit_px & ~&light);
    assign hit_ok      = ~cheat & (light_nxt >= CNT_W'(HIT_THRESHOLD));

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state        <= IDLE;
            trig_q       <= 1'b0;
            det_s1       <= 1'b0;
            det_s2       <= 1'b0;
            vs_q         <= 1'b1;
            cheat        <= 1'b0;
            light        <= '0;
            flash_black  <= 1'b0;
            flash_target <= 1'b0;
            hit          <= 1'b0;
            miss         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            det_s1 <= detect;
            det_s2 <= det_s1;
            vs_q   <= vsync;
            trig_q <= trig_db;
            hit    <= 1'b0;
            miss   <= 1'b0;
            case (state)
                IDLE:
                    if (shot) begin
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                ARM:
                    if (frame_start) begin
                        state       <= BLACK;
                        flash_black <= 1'b1;
                        cheat       <= 1'b0;
                    end
                BLACK: begin
                    // any light during the black frame means the sensor is not looking at the screen
                    if (lit_px)
                        cheat <= 1'b1;
                    if (frame_start) begin
                        state        <= TARGET;
                        flash_black  <= 1'b0;
                        flash_target <= 1'b1;
                        light        <= '0;
                    end
                end
                TARGET: begin
                    light <= light_nxt;
                    if (frame_start) begin
                        state        <= RESULT;
                        flash_target <= 1'b0;
                        hit          <= hit_ok;
                        miss         <= ~hit_ok;
                    end
                end
                RESULT:
                    state <= HOLDOFF;
                HOLDOFF:
                    if (!trig_db) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                default:
                    state <= IDLE;
            endcase
        end
endmodule
